rv_uart_tx: RTL
===============

RV_UART_TX -- requirements
Module: rv_uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_valid  input  1  byte offered by upstream CPU bus.
REQ-007 SHALL have port wr_data  input  8  byte to transmit.
REQ-008 SHALL have port wr_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-012 SHALL accept a byte on any rising edge where wr_valid && wr_ready; wr_data captured that edge.
REQ-013 SHALL drive wr_ready = (fifo_count != FIFO_DEPTH), registered-state derived, no dependence on wr_valid.
REQ-014 SHALL drop nothing: wr_valid while full SHALL leave FIFO contents and count unchanged.
REQ-015 SHALL on simultaneous push and pop (not full) keep fifo_count unchanged and preserve byte order.
REQ-016 SHALL use CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer truncation); each serial bit held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY only reachable when parity compiled in.
REQ-018 SHALL in IDLE with FIFO non-empty pop head byte and enter START on the same edge.
REQ-019 SHALL drive uart_tx low in START, data bits LSB first in DATA (8 bits), high in STOP, high in IDLE.
REQ-020 SHALL transition DATA -> STOP (or PARITY) after bit 7, PARITY -> STOP, STOP -> START if FIFO non-empty else IDLE; no idle gap between back-to-back frames.
REQ-021 SHALL register uart_tx; first start-bit cycle occurs 2 edges after the accepting edge when idle and empty.
REQ-022 SHALL drive busy = (state != IDLE) || (fifo_count != 0).
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with no lost or duplicated entries.

Reset
REQ-024 SHALL on rst_n low immediately force: uart_tx=1, wr_ready=0 while asserted, busy=0, fifo_count=0, state=IDLE, baud counter=0.
REQ-025 SHALL on reset mid-frame abort the frame and flush FIFO; no partial frame resumes after release.
REQ-026 SHALL assert wr_ready=1 on first edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile an even-parity bit when macro RV_UART_TX_PARITY_EN is defined.
REQ-028 With RV_UART_TX_PARITY_EN: frame = start, 8 data, parity (XOR of data bits), stop = 11 bits.
REQ-029 Without RV_UART_TX_PARITY_EN: frame = start, 8 data, stop = 10 bits; no parity logic present.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit, FIFO_DEPTH=4)
REQ-030 Write 0x48 idle -> uart_tx low at edge+2 for 10 cycles, bits 0,0,0,1,0,0,1,0, stop high; 100 cycles total (110 with parity, parity bit 0).
REQ-031 Write 0x48,0x69 back-to-back -> stop of frame 1 followed directly by start of frame 2; busy high throughout, low after final stop.
REQ-032 Write 6 bytes with wr_valid held -> wr_ready low while fifo_count==4; all 6 bytes serialized in order, none lost.
REQ-033 Push and pop same edge at fifo_count=2 -> fifo_count stays 2, output order preserved.
REQ-034 Assert rst_n low at DATA bit 3 -> uart_tx high same cycle, fifo_count=0, busy=0; after release no further start bit without new write.
REQ-035 Parity build, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/rv_uart_tx.sv
// rv_uart_tx: 8-bit UART transmitter with a power-of-two transmit FIFO.
// Define RV_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
`timescale 1ns/1ps
module rv_uart_tx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ZERO  = CW'(0);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ZERO_COUNT = (AW+1)'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

`ifdef RV_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_rdy_en;

    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
`ifdef RV_UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;
    logic          w_baud_last;
    logic [7:0]    w_head;
    logic          w_tx_nxt;

    assign w_not_empty = (r_count != ZERO_COUNT);
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_head      = r_mem[r_rptr];
    assign wr_ready    = r_rdy_en && (r_count != FULL_COUNT);
    assign w_push      = wr_valid && wr_ready;

    assign uart_tx     = r_tx;
    assign busy        = (r_state != ST_IDLE) || w_not_empty;
    assign fifo_count  = r_count;

    // Pop the head byte whenever the FSM is ready to start a new frame.
    always_comb begin
        w_pop = 1'b0;
        if (w_not_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_last))) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Line level for the current state; registered one cycle later into r_tx.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            ST_IDLE:   w_tx_nxt = 1'b1;
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = r_shift[0];
`ifdef RV_UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = r_par;
`endif
            ST_STOP:   w_tx_nxt = 1'b1;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= {AW{1'b0}};
            r_rptr   <= {AW{1'b0}};
            r_count  <= ZERO_COUNT;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer: each state lasts CLKS_PER_BIT cycles, frames chain without gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_baud  <= BAUD_ZERO;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
`ifdef RV_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_baud  <= BAUD_ZERO;
                        r_bit   <= 3'd0;
                        r_shift <= w_head;
`ifdef RV_UART_TX_PARITY_EN
                        r_par   <= even_parity(w_head);
`endif
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud  <= BAUD_ZERO;
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= BAUD_ZERO;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
`ifdef RV_UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
`ifdef RV_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_last) begin
                        r_baud  <= BAUD_ZERO;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= BAUD_ZERO;
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_bit   <= 3'd0;
                            r_shift <= w_head;
`ifdef RV_UART_TX_PARITY_EN
                            r_par   <= even_parity(w_head);
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= BAUD_ZERO;
                end
            endcase
        end
    end

endmodule
